// File: rtl/sc_datapath.sv
// Datapath for the SC_STATEMACHINE shift/add multiplier: register file, BUSA/BUSB muxes,
// ALU with active-low status flags, and RegSHIFTER driving BUSC back into the registers.
module sc_datapath #(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int REGFIX0_VALUE                  = 0
) (
  input  logic                                      SC_STATEMACHINE_CLOCK_50,
  input  logic                                      SC_STATEMACHINE_Reset_InHigh,
  input  logic                                      SC_DATAPATH_LoadOperands_InLow,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_Multiplicand_In,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_Multiplier_In,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_DecoderSelectionWrite_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_MUXSelectionBUSA_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_MUXSelectionBUSB_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DATAPATH_ALUSelection_In,
  input  logic                                      SC_DATAPATH_RegSHIFTERLoad_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DATAPATH_RegSHIFTERShiftSelection_InLow,
  output logic                                      SC_DATAPATH_Overflow_OutLow,
  output logic                                      SC_DATAPATH_Carry_OutLow,
  output logic                                      SC_DATAPATH_Negative_OutLow,
  output logic                                      SC_DATAPATH_Zero_OutLow,
  output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_BUSC_Out,
  output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_Result_Out
);

  localparam int N = DATAWIDTH_BUS;
  localparam logic [N:0] ONE_EXT = (N+1)'(1);

  logic [N-1:0] reg_gen [0:3];
  logic [N-1:0] reg_fix0;
  logic [N-1:0] reg_fix1;
  logic [N-1:0] reg_shifter;
  logic [N-1:0] bus_a;
  logic [N-1:0] bus_b;
  logic [N-1:0] alu_result;
  logic [N:0]   alu_ext;
  logic         alu_carry;
  logic         alu_overflow;

  assign reg_fix0 = N'(REGFIX0_VALUE);

  function automatic logic [N-1:0] bus_mux(
    input logic [DATAWIDTH_MUX_SELECTION-1:0] sel,
    input logic [N-1:0] g0, input logic [N-1:0] g1,
    input logic [N-1:0] g2, input logic [N-1:0] g3,
    input logic [N-1:0] f0, input logic [N-1:0] f1
  );
    logic [N-1:0] v;
    case (sel)
      3'b000:  v = g0;
      3'b001:  v = g1;
      3'b010:  v = g2;
      3'b011:  v = g3;
      3'b100:  v = f0;
      3'b101:  v = f1;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign bus_a = bus_mux(SC_DATAPATH_MUXSelectionBUSA_In, reg_gen[0], reg_gen[1],
                         reg_gen[2], reg_gen[3], reg_fix0, reg_fix1);
  assign bus_b = bus_mux(SC_DATAPATH_MUXSelectionBUSB_In, reg_gen[0], reg_gen[1],
                         reg_gen[2], reg_gen[3], reg_fix0, reg_fix1);

  // Arithmetic runs one bit wider so the top bit gives carry (ADD/INC) or borrow (SUB/DEC).
  always_comb begin
    alu_result   = bus_a;
    alu_ext      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (SC_DATAPATH_ALUSelection_In)
      4'b0001: alu_result = bus_a | bus_b;
      4'b0010: alu_result = bus_a & bus_b;
      4'b0011: alu_result = ~bus_a;
      4'b0100: alu_result = bus_a ^ bus_b;
      4'b1000: begin
        alu_ext      = {1'b0, bus_a} + {1'b0, bus_b};
        alu_result   = alu_ext[N-1:0];
        alu_carry    = alu_ext[N];
        alu_overflow = (bus_a[N-1] == bus_b[N-1]) && (alu_result[N-1] != bus_a[N-1]);
      end
      4'b1001: begin
        alu_ext      = {1'b0, bus_a} - {1'b0, bus_b};
        alu_result   = alu_ext[N-1:0];
        alu_carry    = alu_ext[N];
        alu_overflow = (bus_a[N-1] != bus_b[N-1]) && (alu_result[N-1] != bus_a[N-1]);
      end
      4'b1010: begin
        alu_ext      = {1'b0, bus_a} + ONE_EXT;
        alu_result   = alu_ext[N-1:0];
        alu_carry    = alu_ext[N];
        alu_overflow = ~bus_a[N-1] & alu_result[N-1];
      end
      4'b1011: begin
        alu_ext      = {1'b0, bus_a} - ONE_EXT;
        alu_result   = alu_ext[N-1:0];
        alu_carry    = alu_ext[N];
        alu_overflow = bus_a[N-1] & ~alu_result[N-1];
      end
      default: alu_result = bus_a;
    endcase
  end

  assign SC_DATAPATH_Zero_OutLow     = |alu_result;
  assign SC_DATAPATH_Negative_OutLow = ~alu_result[N-1];
  assign SC_DATAPATH_Carry_OutLow    = ~alu_carry;
  assign SC_DATAPATH_Overflow_OutLow = ~alu_overflow;

  // Register writes take the pre-edge shifter value; operand load overrides a write to RegGEN1.
  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_Reset_InHigh) begin
    if (SC_STATEMACHINE_Reset_InHigh) begin
      for (int i = 0; i < 4; i++) reg_gen[i] <= '0;
      reg_fix1 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if ((i == 1) && !SC_DATAPATH_LoadOperands_InLow)
          reg_gen[i] <= SC_DATAPATH_Multiplicand_In;
        else if (SC_DATAPATH_DecoderSelectionWrite_In == DATAWIDTH_DECODER_SELECTION'(i))
          reg_gen[i] <= reg_shifter;
      end
      if (!SC_DATAPATH_LoadOperands_InLow)
        reg_fix1 <= SC_DATAPATH_Multiplier_In;
    end
  end

  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_Reset_InHigh) begin
    if (SC_STATEMACHINE_Reset_InHigh)
      reg_shifter <= '0;
    else if (!SC_DATAPATH_RegSHIFTERLoad_InLow) begin
      case (SC_DATAPATH_RegSHIFTERShiftSelection_InLow)
        2'b01:   reg_shifter <= {reg_shifter[N-2:0], 1'b0};
        2'b10:   reg_shifter <= {1'b0, reg_shifter[N-1:1]};
        default: reg_shifter <= alu_result;
      endcase
    end
  end

  assign SC_DATAPATH_BUSC_Out   = reg_shifter;
  assign SC_DATAPATH_Result_Out = reg_gen[3];

endmodule

// File: doc/sc_datapath.md
Name: sc_datapath

Overview:
- Datapath that consumes the microinstruction fields produced by the SC_STATEMACHINE controller and returns its four active-low status flags.
- Contains:
  - four general registers (RegGEN0..3) and two fixed registers (RegFIX0, RegFIX1);
  - BUSA/BUSB read multiplexers and a combinational ALU;
  - RegSHIFTER, which drives BUSC;
  - a write decoder from BUSC into the general registers.
- Used by the shift/add multiplier program: RegGEN1 holds the multiplicand, RegFIX1 the multiplier, RegGEN3 the accumulated result.

Parameters:
- DATAWIDTH_BUS, 8, width of every register and bus.
- DATAWIDTH_DECODER_SELECTION, 3, write-decoder select width.
- DATAWIDTH_MUX_SELECTION, 3, BUSA/BUSB select width.
- DATAWIDTH_ALU_SELECTION, 4, ALU opcode width.
- DATAWIDTH_REGSHIFTER_SELECTION, 2, shift select width.
- REGFIX0_VALUE, 0, constant held in RegFIX0.

Ports:
- SC_STATEMACHINE_CLOCK_50  in  1  system clock, rising edge.
- SC_STATEMACHINE_Reset_InHigh  in  1  asynchronous, active-high reset.
- SC_DATAPATH_LoadOperands_InLow  in  1  0 = capture operands on this edge.
- SC_DATAPATH_Multiplicand_In  in  DATAWIDTH_BUS  loaded into RegGEN1.
- SC_DATAPATH_Multiplier_In  in  DATAWIDTH_BUS  loaded into RegFIX1.
- SC_DATAPATH_DecoderSelectionWrite_In  in  DATAWIDTH_DECODER_SELECTION  000-011 write RegGEN0-3; 100-111 no write.
- SC_DATAPATH_MUXSelectionBUSA_In  in  DATAWIDTH_MUX_SELECTION  000-011 RegGEN0-3; 100 RegFIX0; 101 RegFIX1; 110/111 zero.
- SC_DATAPATH_MUXSelectionBUSB_In  in  DATAWIDTH_MUX_SELECTION  same encoding as BUSA.
- SC_DATAPATH_ALUSelection_In  in  DATAWIDTH_ALU_SELECTION  ALU opcode.
- SC_DATAPATH_RegSHIFTERLoad_InLow  in  1  0 = RegSHIFTER updates this edge.
- SC_DATAPATH_RegSHIFTERShiftSelection_InLow  in  DATAWIDTH_REGSHIFTER_SELECTION  01 shift left; 10 shift right; 00/11 load ALU result.
- SC_DATAPATH_Overflow_OutLow, SC_DATAPATH_Carry_OutLow, SC_DATAPATH_Negative_OutLow, SC_DATAPATH_Zero_OutLow  out  1 each  status flags, 0 = asserted.
- SC_DATAPATH_BUSC_Out  out  DATAWIDTH_BUS  RegSHIFTER contents.
- SC_DATAPATH_Result_Out  out  DATAWIDTH_BUS  RegGEN3 contents.

Behaviour:
- Reset (async, SC_STATEMACHINE_Reset_InHigh=1):
  - RegGEN0..3, RegFIX1 and RegSHIFTER cleared to 0.
  - Therefore BUSC_Out=0 and Result_Out=0.
  - Flags follow the combinational rules below from the reset register values.
  - Reset asserted mid-operation discards all state immediately, independent of the clock.
- RegFIX0:
  - Constant REGFIX0_VALUE; never written.
- Operand load (rising edge with LoadOperands_InLow=0):
  - RegGEN1 <= Multiplicand_In; RegFIX1 <= Multiplier_In.
  - If the decoder selects RegGEN1 on the same edge, the operand load wins.
- BUSA/BUSB:
  - Combinational mux per the select encoding.
  - Selects 110/111 drive zero.
- ALU (combinational; A=BUSA, B=BUSB; N=DATAWIDTH_BUS-bit results):
  - 0000 A; 0001 A|B; 0010 A&B; 0011 ~A; 0100 A^B; 0101-0111 A.
  - 1000 A+B; 1001 A-B; 1010 A+1; 1011 A-1; 1100-1111 A.
  - Arithmetic wraps modulo 2^N.
- Flags (combinational from the current ALU result, active-low):
  - Zero: result==0.
  - Negative: result MSB.
  - Carry:
    - ADD/INC: carry out of the MSB.
    - SUB/DEC: borrow, i.e. A<B for SUB, A==0 for DEC.
    - Logic/pass opcodes: 0.
  - Overflow:
    - Signed two's-complement overflow for ADD/SUB/INC/DEC.
    - 0 otherwise.
  - Example: ADD 0xFF+0x01 -> result 0x00, Zero_OutLow=0, Carry_OutLow=0, Overflow_OutLow=1, Negative_OutLow=1.
- RegSHIFTER (rising edge, only when Load_InLow=0):
  - Shift select 00/11: load ALU result.
  - 01: Q <= {Q[N-2:0],0}.
  - 10: Q <= {0,Q[N-1:1]}.
  - Load_InLow=1: hold.
- Register write (rising edge):
  - Decoder 000-011: RegGEN[sel] <= RegSHIFTER Q, i.e. the value before any same-edge RegSHIFTER update.
  - Decoder 100-111: no write.
- Latency for a controller op:
  - Cycle 0: operands selected.
  - Edge 1 (Load_InLow=0): RegSHIFTER captures the result.
  - Edge 2 (decoder write): destination updated.
  - Total: 2 edges after operand select.
- Write-while-read: a register selected on BUSA and written on the same edge reads its old value that cycle; the new value is visible the next cycle.

Test Plan:
- Reset mid-operation:
  - Stimulus: Reset pulse asynchronously while RegGEN3=0x2A and RegSHIFTER=0x15.
  - Response: Result_Out=0 and BUSC_Out=0 immediately, before the next clock edge.
- Operand load plus move:
  - Stimulus: load Multiplicand=0x07, Multiplier=0x03; then BUSA=101, ALU=0000, Load low one edge, decoder=010 next edge.
  - Response: RegGEN2=0x03; BUSA=001 shows 0x07.
- Add sequence:
  - Stimulus: RegGEN3=0x10, RegGEN1=0x07; run the three-cycle add (BUSA=011, BUSB=001, ALU=1000, Load low, then decoder=011).
  - Response: Result_Out=0x17 after the second edge; unchanged after the first edge.
- Flags:
  - DEC of 0x01: Zero_OutLow=0.
  - DEC of 0x00: result 0xFF, Carry_OutLow=0, Negative_OutLow=0.
  - ADD 0x7F+0x01: Overflow_OutLow=0.
- Shifter:
  - Load 0x81, shift 01: BUSC_Out=0x02.
  - Load 0x81, shift 10: BUSC_Out=0x40.
  - Load_InLow=1 with shift 01: value held.
- Full 7x3 multiplication:
  - Stimulus: drive the controller's MOV/DEC/ADD sequence through the datapath.
  - Response: Result_Out=0x15; Zero_OutLow goes 0 when RegGEN2 decrements to 0.
  - Simultaneous case: operand load and decoder write to RegGEN1 on the same edge -> RegGEN1 takes Multiplicand_In.
